// File: rtl/maxnet_param.sv
// maxnet_param: N-channel Maxnet winner-take-all selector with start/done handshake
module maxnet_param #(
  parameter int N = 4,
  parameter int W = 32,
  parameter int FRAC = 16,
  parameter int MAX_ITER = 64,
  localparam int IDX_W = ($clog2(N) > 1) ? $clog2(N) : 1,
  localparam int CNT_W = $clog2(MAX_ITER + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [N*W-1:0]   x_in,
  input  logic [W-1:0]     eps,
  output logic             busy,
  output logic             done,
  output logic [W-1:0]     result,
  output logic [IDX_W-1:0] winner_idx,
  output logic             winner_valid,
  output logic             timeout,
  output logic [CNT_W-1:0] iter_count
);
  localparam int SW = W + IDX_W;
  localparam int PW = W + SW;
  localparam int NZ_W = IDX_W + 1;
  typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;
  state_t state_q, state_d;
  logic [W-1:0] ch_q [N];
  logic [W-1:0] ch_d [N];
  logic [W-1:0] nxt [N];
  logic [PW-1:0] p [N];
  logic [W-1:0] eps_q, eps_d, result_q, result_d, sel;
  logic [IDX_W-1:0] idx_q, idx_d, sel_idx;
  logic valid_q, valid_d, timeout_q, timeout_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SW-1:0] s;
  logic [NZ_W-1:0] nz;
  always_comb begin
    s = '0;
    nz = '0;
    sel = '0;
    sel_idx = '0;
    for (int i = 0; i < N; i++) begin
      s = s + SW'(ch_q[i]);
      if (ch_q[i] != '0) begin
        nz = nz + NZ_W'(1);
        sel = ch_q[i];
        sel_idx = IDX_W'(i);
      end
    end
  end
  genvar i;
  for (i = 0; i < N; i++) begin : g_ch
    assign p[i] = (PW'(eps_q) * PW'(s - SW'(ch_q[i]))) >> FRAC;
    assign nxt[i] = (p[i] >= PW'(ch_q[i])) ? '0 : ch_q[i] - p[i][W-1:0];
  end
  always_comb begin
    state_d = state_q;
    ch_d = ch_q;
    eps_d = eps_q;
    result_d = result_q;
    idx_d = idx_q;
    valid_d = valid_q;
    timeout_d = timeout_q;
    cnt_d = cnt_q;
    if (state_q == IDLE && start) begin
      for (int j = 0; j < N; j++)
        ch_d[j] = x_in[j*W+W-1] ? '0 : x_in[j*W +: W];
      eps_d = eps;
      cnt_d = '0;
      result_d = '0;
      idx_d = '0;
      valid_d = 1'b0;
      timeout_d = 1'b0;
      state_d = ITER;
    end else if (state_q == ITER) begin
      if (nz <= NZ_W'(1)) begin
        state_d = DONE;
        valid_d = nz == NZ_W'(1);
        result_d = (nz == NZ_W'(1)) ? sel : '0;
        idx_d = (nz == NZ_W'(1)) ? sel_idx : '0;
      end else if (cnt_q == CNT_W'(MAX_ITER)) begin
        state_d = DONE;
        timeout_d = 1'b1;
      end else begin
        ch_d = nxt;
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ch_q <= '{default: '0};
      eps_q <= '0;
      result_q <= '0;
      idx_q <= '0;
      valid_q <= 1'b0;
      timeout_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      ch_q <= ch_d;
      eps_q <= eps_d;
      result_q <= result_d;
      idx_q <= idx_d;
      valid_q <= valid_d;
      timeout_q <= timeout_d;
      cnt_q <= cnt_d;
    end
  end
  assign busy = state_q != IDLE;
  assign done = state_q == DONE;
  assign result = result_q;
  assign winner_idx = idx_q;
  assign winner_valid = valid_q;
  assign timeout = timeout_q;
  assign iter_count = cnt_q;
endmodule

// File: tb/tb_maxnet_param.sv
// tb_maxnet_param: directed checks of maxnet_param at default and N=8/W=16/FRAC=8 sizes
module tb_maxnet_param;
  logic clk = 1'b0;
  logic rst, start, start8;
  logic [127:0] x_in, x8;
  logic [31:0] eps;
  logic [15:0] eps8;
  logic busy, done, wvalid, tmo, busy8, done8, wvalid8, tmo8;
  logic [31:0] result;
  logic [15:0] result8;
  logic [1:0] widx;
  logic [2:0] widx8;
  logic [6:0] iter, iter8;
  int tests = 0;
  int fails = 0;

  maxnet_param u_dut (
    .clk(clk), .rst(rst), .start(start), .x_in(x_in), .eps(eps),
    .busy(busy), .done(done), .result(result), .winner_idx(widx),
    .winner_valid(wvalid), .timeout(tmo), .iter_count(iter)
  );

  maxnet_param #(.N(8), .W(16), .FRAC(8), .MAX_ITER(64)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .x_in(x8), .eps(eps8),
    .busy(busy8), .done(done8), .result(result8), .winner_idx(widx8),
    .winner_valid(wvalid8), .timeout(tmo8), .iter_count(iter8)
  );

  always #5 clk = ~clk;

  task automatic run4(input logic [127:0] x, input logic [31:0] e, output int cyc);
    @(posedge clk); #1;
    x_in = x; eps = e; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    while (!done && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic run8(input logic [127:0] x, input logic [15:0] e, output int cyc);
    @(posedge clk); #1;
    x8 = x; eps8 = e; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    cyc = 1;
    while (!done8 && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; start8 = 1'b0;
    x_in = '1; eps = '1; x8 = '0; eps8 = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done got %b want 0", done); end
    tests++; if (result !== 32'h0) begin fails++; $display("FAIL reset_result got %h want 0", result); end
    tests++; if (widx !== 2'd0) begin fails++; $display("FAIL reset_idx got %0d want 0", widx); end
    tests++; if (wvalid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b want 0", wvalid); end
    tests++; if (tmo !== 1'b0) begin fails++; $display("FAIL reset_timeout got %b want 0", tmo); end
    tests++; if (iter !== 7'd0) begin fails++; $display("FAIL reset_iter got %0d want 0", iter); end
    tests++; if (busy8 !== 1'b0 || done8 !== 1'b0) begin fails++; $display("FAIL reset8_flags got busy=%b done=%b want 0 0", busy8, done8); end
  endtask

  task automatic test_single_winner;
    int cyc;
    run4({32'h0, 32'h00050000, 32'h0, 32'h0}, 32'h00012345, cyc);
    tests++; if (cyc !== 2) begin fails++; $display("FAIL single_latency got %0d want 2", cyc); end
    tests++; if (wvalid !== 1'b1) begin fails++; $display("FAIL single_valid got %b want 1", wvalid); end
    tests++; if (widx !== 2'd2) begin fails++; $display("FAIL single_idx got %0d want 2", widx); end
    tests++; if (result !== 32'h00050000) begin fails++; $display("FAIL single_result got %h want 00050000", result); end
    tests++; if (iter !== 7'd0) begin fails++; $display("FAIL single_iter got %0d want 0", iter); end
    tests++; if (tmo !== 1'b0) begin fails++; $display("FAIL single_timeout got %b want 0", tmo); end
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL single_busy_done got %b want 1", busy); end
    @(posedge clk); #1;
    tests++; if (done !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL single_pulse got done=%b busy=%b want 0 0", done, busy); end
    tests++; if (result !== 32'h00050000 || widx !== 2'd2) begin fails++; $display("FAIL single_hold got %h/%0d want 00050000/2", result, widx); end
  endtask

  task automatic test_two_channel;
    int cyc;
    run4({32'h0, 32'h0, 32'h00020000, 32'h00010000}, 32'h00008000, cyc);
    tests++; if (cyc !== 3) begin fails++; $display("FAIL two_latency got %0d want 3", cyc); end
    tests++; if (wvalid !== 1'b1) begin fails++; $display("FAIL two_valid got %b want 1", wvalid); end
    tests++; if (widx !== 2'd1) begin fails++; $display("FAIL two_idx got %0d want 1", widx); end
    tests++; if (result !== 32'h00018000) begin fails++; $display("FAIL two_result got %h want 00018000", result); end
    tests++; if (iter !== 7'd1) begin fails++; $display("FAIL two_iter got %0d want 1", iter); end
  endtask

  task automatic test_tie_zero;
    int cyc;
    run4({32'h0, 32'h0, 32'h00010000, 32'h00010000}, 32'h00010000, cyc);
    tests++; if (cyc !== 3) begin fails++; $display("FAIL tiez_latency got %0d want 3", cyc); end
    tests++; if (wvalid !== 1'b0) begin fails++; $display("FAIL tiez_valid got %b want 0", wvalid); end
    tests++; if (tmo !== 1'b0) begin fails++; $display("FAIL tiez_timeout got %b want 0", tmo); end
    tests++; if (iter !== 7'd1) begin fails++; $display("FAIL tiez_iter got %0d want 1", iter); end
    tests++; if (result !== 32'h0 || widx !== 2'd0) begin fails++; $display("FAIL tiez_result got %h/%0d want 0/0", result, widx); end
  endtask

  task automatic test_tie_timeout;
    int cyc;
    run4({32'h0, 32'h0, 32'h00010000, 32'h00010000}, 32'h00008000, cyc);
    tests++; if (cyc !== 66) begin fails++; $display("FAIL tiet_latency got %0d want 66", cyc); end
    tests++; if (tmo !== 1'b1) begin fails++; $display("FAIL tiet_timeout got %b want 1", tmo); end
    tests++; if (wvalid !== 1'b0) begin fails++; $display("FAIL tiet_valid got %b want 0", wvalid); end
    tests++; if (iter !== 7'd64) begin fails++; $display("FAIL tiet_iter got %0d want 64", iter); end
    tests++; if (result !== 32'h0 || widx !== 2'd0) begin fails++; $display("FAIL tiet_result got %h/%0d want 0/0", result, widx); end
  endtask

  task automatic test_negative_clamp;
    int cyc;
    run4({32'h00020000, 32'h0, 32'h0, 32'hFFFD0000}, 32'h00008000, cyc);
    tests++; if (cyc !== 2) begin fails++; $display("FAIL clamp_latency got %0d want 2", cyc); end
    tests++; if (widx !== 2'd3) begin fails++; $display("FAIL clamp_idx got %0d want 3", widx); end
    tests++; if (result !== 32'h00020000) begin fails++; $display("FAIL clamp_result got %h want 00020000", result); end
    tests++; if (iter !== 7'd0 || tmo !== 1'b0) begin fails++; $display("FAIL clamp_iter got %0d/%b want 0/0", iter, tmo); end
  endtask

  task automatic test_start_ignored;
    int cyc;
    @(posedge clk); #1;
    x_in = {32'h0, 32'h0, 32'h00020000, 32'h00010000}; eps = 32'h00008000; start = 1'b1;
    @(posedge clk); #1;
    x_in = {32'h00070000, 32'h0, 32'h0, 32'h00010000}; eps = 32'h00010000;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 2;
    while (!done && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    tests++; if (cyc !== 3) begin fails++; $display("FAIL busy_latency got %0d want 3", cyc); end
    tests++; if (widx !== 2'd1 || result !== 32'h00018000) begin fails++; $display("FAIL busy_result got %0d/%h want 1/00018000", widx, result); end
    tests++; if (iter !== 7'd1) begin fails++; $display("FAIL busy_iter got %0d want 1", iter); end
    @(posedge clk); #1;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL busy_idle got %b want 0", busy); end
  endtask

  task automatic test_reset_mid_run;
    int cyc;
    logic saw_done;
    @(posedge clk); #1;
    x_in = {32'h0, 32'h0, 32'h00020000, 32'h00010000}; eps = 32'h00008000; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    tests++; if (iter !== 7'd1 || busy !== 1'b1) begin fails++; $display("FAIL mid_state got iter=%0d busy=%b want 1 1", iter, busy); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    tests++; if (busy !== 1'b0 || done !== 1'b0) begin fails++; $display("FAIL mid_flags got busy=%b done=%b want 0 0", busy, done); end
    tests++; if (result !== 32'h0 || widx !== 2'd0 || iter !== 7'd0) begin fails++; $display("FAIL mid_outputs got %h/%0d/%0d want 0/0/0", result, widx, iter); end
    tests++; if (wvalid !== 1'b0 || tmo !== 1'b0) begin fails++; $display("FAIL mid_status got %b/%b want 0/0", wvalid, tmo); end
    saw_done = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      saw_done |= done;
    end
    tests++; if (saw_done !== 1'b0) begin fails++; $display("FAIL mid_no_done got %b want 0", saw_done); end
    run4({32'h0, 32'h00050000, 32'h0, 32'h0}, 32'h00008000, cyc);
    tests++; if (cyc !== 2 || widx !== 2'd2 || wvalid !== 1'b1) begin fails++; $display("FAIL mid_restart got cyc=%0d idx=%0d valid=%b want 2 2 1", cyc, widx, wvalid); end
  endtask

  task automatic test_param8;
    int cyc;
    run8({16'd35, 16'd25, 16'd15, 16'd5, 16'd800, 16'd30, 16'd20, 16'd10}, 16'h0020, cyc);
    tests++; if (cyc !== 3) begin fails++; $display("FAIL p8a_latency got %0d want 3", cyc); end
    tests++; if (widx8 !== 3'd3 || wvalid8 !== 1'b1) begin fails++; $display("FAIL p8a_idx got %0d/%b want 3/1", widx8, wvalid8); end
    tests++; if (result8 !== 16'h030F) begin fails++; $display("FAIL p8a_result got %h want 030f", result8); end
    tests++; if (iter8 !== 7'd1) begin fails++; $display("FAIL p8a_iter got %0d want 1", iter8); end
    run8({16'd60, 16'd350, 16'd150, 16'd250, 16'd50, 16'd300, 16'd200, 16'd100}, 16'h0020, cyc);
    tests++; if (cyc !== 10) begin fails++; $display("FAIL p8b_latency got %0d want 10", cyc); end
    tests++; if (widx8 !== 3'd6 || wvalid8 !== 1'b1) begin fails++; $display("FAIL p8b_idx got %0d/%b want 6/1", widx8, wvalid8); end
    tests++; if (result8 !== 16'h0080) begin fails++; $display("FAIL p8b_result got %h want 0080", result8); end
    tests++; if (iter8 !== 7'd8 || tmo8 !== 1'b0) begin fails++; $display("FAIL p8b_iter got %0d/%b want 8/0", iter8, tmo8); end
  endtask

  initial begin
    test_reset();
    test_single_winner();
    test_two_channel();
    test_tie_zero();
    test_tie_timeout();
    test_negative_clamp();
    test_start_ignored();
    test_reset_mid_run();
    test_param8();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
